rvvi_host_cmd_rx: RTL
=====================

Name: rvvi_host_cmd_rx

Overview:
- Parametrised host-command receiver for the RVVI hardware tracer. It replaces the per-command single-string trigger matchers with one N-channel engine on the Ethernet MAC's RX AXI-stream.
- Each received frame's header is compared against NUM_CMDS programmable header strings, with per-byte don't-care masks.
- On a match it captures a multi-word payload and commits it only once the frame ends cleanly.
- Outputs one-cycle command pulses and held payload registers to the tracer top (ILA trigger, slow-down, rate set, ...).

Parameters:
- AXIS_WIDTH, 32, RX stream data width in bits; must be 32 or 64.
- HDR_BYTES, 20, header bytes compared: dst MAC, src MAC, EtherType, 6-byte tag. HDR_BYTES*8 must be a multiple of AXIS_WIDTH.
- NUM_CMDS, 3, number of command channels.
- PAYLOAD_WORDS, 1, AXIS_WIDTH-bit payload words captured after the header, per command.
- CNT_WIDTH, 16, width of the saturating error counters.

Ports:
- clk  in  1  tracer logic clock
- reset  in  1  synchronous, active-high reset
- CmdStrings  in  NUM_CMDS x HDR_BYTES*8  expected header per command; byte 0 is bits [7:0]
- CmdMasks  in  NUM_CMDS x HDR_BYTES  1 = compare this byte, 0 = don't care
- CmdDefaults  in  NUM_CMDS x PAYLOAD_WORDS*AXIS_WIDTH  payload values loaded during reset
- RxTdata  in  AXIS_WIDTH  RX stream data; first byte on [7:0]
- RxTkeep  in  AXIS_WIDTH/8  byte-valid strobes
- RxTvalid  in  1  beat valid; stream is always accepted, no tready
- RxTlast  in  1  last beat of frame
- RxTuser  in  1  bad-frame/FCS flag, qualified with RxTlast
- CmdPulse  out  NUM_CMDS  one-cycle strobe on committed command
- CmdPayload  out  NUM_CMDS x PAYLOAD_WORDS*AXIS_WIDTH  last committed payload per command
- BadFrameCount  out  CNT_WIDTH  frames dropped because of RxTuser
- RuntCount  out  CNT_WIDTH  matching frames truncated before the payload completed

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values: state HDR; beat index 0; candidate vector all ones; CmdPulse 0; both counters 0. While reset is held, CmdPayload[i] is loaded from CmdDefaults[i] every cycle.
- Constants: HDR_BEATS = HDR_BYTES*8/AXIS_WIDTH.
- Only beats with RxTvalid=1 advance any state.
- HDR state, beat k: candidate bit i is cleared if any byte b with CmdMasks[i][b]=1 either mismatches CmdStrings[i] or has RxTkeep low.
  - After beat HDR_BEATS-1: go to PAYLOAD if the updated candidate vector is nonzero, otherwise DROP.
- Channel priority: the lowest-index surviving candidate is latched as the selected channel at header end. Only that channel can commit.
- PAYLOAD state:
  - Each beat is written to shadow word w, w = 0..PAYLOAD_WORDS-1.
  - After the last word, go to TAIL.
  - Beats in TAIL are ignored; this absorbs Ethernet padding and FCS-stripped trailers.
- Frame end (RxTlast on an accepted beat), in any state:
  - RxTuser=1: discard; BadFrameCount increments.
  - Otherwise, in TAIL, or on the final payload beat: commit. Shadow copies into CmdPayload[sel] and CmdPulse[sel]=1, both visible the cycle after the RxTlast beat.
  - Otherwise, if the frame was still a candidate (mid-HDR with a nonzero vector, or mid-PAYLOAD): discard; RuntCount increments.
  - Non-matching frames (DROP) are discarded silently.
  - In every case, return to HDR with index 0 and the candidate vector all ones.
- RxTuser with RxTlast on a runt: counts as bad frame only, never both counters.
- Counters saturate at all ones and do not wrap.
- CmdPulse is never asserted for more than one cycle and never for more than one channel.
- The shadow buffer never alters CmdPayload on a discarded frame.
- CmdStrings, CmdMasks and CmdDefaults are quasi-static; changing them mid-frame affects only beats compared afterwards.
- Reset mid-frame aborts the frame: no pulse, no counter update. The next accepted beat is treated as header beat 0.
- An all-zero CmdMasks[i] matches every frame that is long enough.

Decomposition:
- Shared RVVI package holds:
  - the rx state enum (HDR, PAYLOAD, TAIL, DROP);
  - the HDR_BEATS derivation function;
  - the standard tracer command header localparams: trigger, slow-down, rate-set strings and the EtherType 16'h005c.
- One sub-module, rvvi_hdr_beat_match: combinational per-channel, per-beat byte compare with mask and keep. It is instantiated NUM_CMDS times via generate.

Test Plan:
- Default configuration, all masks all-ones; frame = rate-set header (5 beats) + payload 32'h0000_0040 + 9 pad beats with tlast. Expect CmdPulse = 3'b100 for exactly 1 cycle after tlast, CmdPayload[2] = 32'h40, other payloads unchanged.
- Reset with CmdDefaults[2] = 32'd2; no traffic. Expect CmdPayload[2] = 2, counters 0, CmdPulse 0.
- Rate-set frame with tlast on header beat 3. Expect RuntCount = 1, no pulse, CmdPayload[2] still 2. Repeat with RxTuser=1: BadFrameCount = 1, RuntCount unchanged.
- Channels 0 and 1 both programmed to match the same frame (channel 1 mask 0 on the tag bytes). Expect pulse on channel 0 only.
- Frame with dst MAC byte 0 = 8'h44 instead of 8'h43. Expect no pulse or counter change; a back-to-back valid trigger frame next cycle pulses channel 0.
- Force RuntCount to all ones minus 1, send 3 runts. Expect the count to saturate at 16'hFFFF. Assert reset mid-payload: no pulse, and the following frame matches normally.

Source files
------------

// File: rtl/rvvi_host_cmd_rx_pkg.sv
// Shared RVVI host-command definitions.
//   - rx_state_e : receiver frame-parsing states
//   - hdr_beats  : number of stream beats that carry the compared header
//   - Standard tracer command headers (20 bytes, byte 0 in bits [7:0]):
//     dst MAC, src MAC, EtherType 16'h005c (wire order), 6-byte ASCII tag.
package rvvi_host_cmd_rx_pkg;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DROP
    } rx_state_e;

    function automatic int unsigned hdr_beats(input int unsigned hdr_bytes,
                                              input int unsigned axis_width);
        return (hdr_bytes * 8) / axis_width;
    endfunction

    localparam logic [47:0] RVVI_DST_MAC   = 48'h66_55_44_33_02_43;
    localparam logic [47:0] RVVI_SRC_MAC   = 48'h0A_00_00_35_0A_02;
    localparam logic [15:0] RVVI_ETHERTYPE = 16'h005c;
    // EtherType travels MSB first, so its high byte is header byte 12.
    localparam logic [15:0] RVVI_ETYPE_BYTES = {RVVI_ETHERTYPE[7:0], RVVI_ETHERTYPE[15:8]};

    // ASCII tags, first character in the low byte.
    localparam logic [47:0] RVVI_TAG_TRIGGER  = 48'h52_47_47_49_52_54; // "TRIGGR"
    localparam logic [47:0] RVVI_TAG_SLOWDOWN = 48'h4E_44_57_4F_4C_53; // "SLOWDN"
    localparam logic [47:0] RVVI_TAG_RATESET  = 48'h54_53_45_54_41_52; // "RATEST"

    localparam logic [159:0] RVVI_HDR_TRIGGER =
        {RVVI_TAG_TRIGGER, RVVI_ETYPE_BYTES, RVVI_SRC_MAC, RVVI_DST_MAC};
    localparam logic [159:0] RVVI_HDR_SLOWDOWN =
        {RVVI_TAG_SLOWDOWN, RVVI_ETYPE_BYTES, RVVI_SRC_MAC, RVVI_DST_MAC};
    localparam logic [159:0] RVVI_HDR_RATESET =
        {RVVI_TAG_RATESET, RVVI_ETYPE_BYTES, RVVI_SRC_MAC, RVVI_DST_MAC};

endpackage

// File: rtl/rvvi_hdr_beat_match.sv
// Combinational compare of one header beat against one channel's expected
// header slice.
//   beat_data_i / beat_keep_i : current RX beat and its byte strobes
//   expect_i / mask_i         : expected bytes and compare-enable per byte
//   hit_o                     : 1 when every enabled byte is present and equal
module rvvi_hdr_beat_match
    import rvvi_host_cmd_rx_pkg::*;
#(
    parameter int unsigned AXIS_WIDTH = 32
) (
    input  logic [AXIS_WIDTH-1:0]   beat_data_i,
    input  logic [AXIS_WIDTH/8-1:0] beat_keep_i,
    input  logic [AXIS_WIDTH-1:0]   expect_i,
    input  logic [AXIS_WIDTH/8-1:0] mask_i,
    output logic                    hit_o
);

    localparam int unsigned NBYTES = AXIS_WIDTH / 8;

    always_comb begin
        hit_o = 1'b1;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            // A compared byte that is absent counts as a mismatch.
            if (mask_i[b] && (!beat_keep_i[b] ||
                              (beat_data_i[8*b +: 8] != expect_i[8*b +: 8]))) begin
                hit_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rvvi_host_cmd_rx.sv
// N-channel host-command receiver on the MAC RX AXI-stream.
//   clk, reset      : tracer clock, synchronous active-high reset
//   CmdStrings      : expected header per channel (byte 0 in [7:0])
//   CmdMasks        : per-byte compare enable per channel
//   CmdDefaults     : payload values loaded while reset is held
//   RxT*            : RX stream (no backpressure); RxTuser valid with RxTlast
//   CmdPulse        : one-cycle strobe for the committed channel
//   CmdPayload      : last committed payload per channel
//   BadFrameCount   : saturating count of RxTuser-flagged frames
//   RuntCount       : saturating count of matching frames cut short
module rvvi_host_cmd_rx
    import rvvi_host_cmd_rx_pkg::*;
#(
    parameter int unsigned AXIS_WIDTH    = 32,
    parameter int unsigned HDR_BYTES     = 20,
    parameter int unsigned NUM_CMDS      = 3,
    parameter int unsigned PAYLOAD_WORDS = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_CMDS-1:0][HDR_BYTES*8-1:0]          CmdStrings,
    input  logic [NUM_CMDS-1:0][HDR_BYTES-1:0]            CmdMasks,
    input  logic [NUM_CMDS-1:0][PAYLOAD_WORDS*AXIS_WIDTH-1:0] CmdDefaults,
    input  logic [AXIS_WIDTH-1:0]                         RxTdata,
    input  logic [AXIS_WIDTH/8-1:0]                       RxTkeep,
    input  logic                                          RxTvalid,
    input  logic                                          RxTlast,
    input  logic                                          RxTuser,
    output logic [NUM_CMDS-1:0]                           CmdPulse,
    output logic [NUM_CMDS-1:0][PAYLOAD_WORDS*AXIS_WIDTH-1:0] CmdPayload,
    output logic [CNT_WIDTH-1:0]                          BadFrameCount,
    output logic [CNT_WIDTH-1:0]                          RuntCount
);

    localparam int unsigned HDR_BEATS = hdr_beats(HDR_BYTES, AXIS_WIDTH);
    localparam int unsigned KEEP_W    = AXIS_WIDTH / 8;
    localparam int unsigned PW_BITS   = PAYLOAD_WORDS * AXIS_WIDTH;
    localparam int unsigned IDX_MAX   = (HDR_BEATS > PAYLOAD_WORDS) ? HDR_BEATS : PAYLOAD_WORDS;
    localparam int unsigned IDX_W     = $clog2(IDX_MAX + 1);
    localparam int unsigned SEL_W     = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

    rx_state_e                               state_q, state_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic [NUM_CMDS-1:0]                     cand_q, cand_d;
    logic [SEL_W-1:0]                        sel_q, sel_d;
    logic [PAYLOAD_WORDS-1:0][AXIS_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_CMDS-1:0][PW_BITS-1:0]        payload_q, payload_d;
    logic [NUM_CMDS-1:0]                     pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0]                    bad_q, bad_d;
    logic [CNT_WIDTH-1:0]                    runt_q, runt_d;

    logic [NUM_CMDS-1:0] hit;
    logic [NUM_CMDS-1:0] cand_upd;
    logic [IDX_W-1:0]    hdr_idx;
    logic [31:0]         str_base;
    logic [31:0]         msk_base;
    logic [SEL_W-1:0]    lowest_sel;
    logic                found;
    logic                last_word;

    // Index is shared with payload words; clamp so header selects stay in range.
    always_comb begin
        hdr_idx  = (idx_q < IDX_W'(HDR_BEATS)) ? idx_q : '0;
        str_base = 32'(hdr_idx) * AXIS_WIDTH;
        msk_base = 32'(hdr_idx) * KEEP_W;
    end

    for (genvar i = 0; i < NUM_CMDS; i++) begin : g_match
        rvvi_hdr_beat_match #(
            .AXIS_WIDTH(AXIS_WIDTH)
        ) u_match (
            .beat_data_i(RxTdata),
            .beat_keep_i(RxTkeep),
            .expect_i   (CmdStrings[i][str_base +: AXIS_WIDTH]),
            .mask_i     (CmdMasks[i][msk_base +: KEEP_W]),
            .hit_o      (hit[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cand_d     = cand_q;
        sel_d      = sel_q;
        shadow_d   = shadow_q;
        payload_d  = payload_q;
        pulse_d    = '0;
        bad_d      = bad_q;
        runt_d     = runt_q;
        cand_upd   = cand_q & hit;
        last_word  = (idx_q == IDX_W'(PAYLOAD_WORDS - 1));
        lowest_sel = '0;
        found      = 1'b0;

        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            if (cand_upd[i] && !found) begin
                lowest_sel = SEL_W'(i);
                found      = 1'b1;
            end
        end

        if (RxTvalid) begin
            unique case (state_q)
                ST_HDR: begin
                    cand_d = cand_upd;
                    if (idx_q == IDX_W'(HDR_BEATS - 1)) begin
                        idx_d   = '0;
                        sel_d   = lowest_sel;
                        state_d = (|cand_upd) ? ST_PAYLOAD : ST_DROP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    for (int unsigned w = 0; w < PAYLOAD_WORDS; w++) begin
                        if (idx_q == IDX_W'(w)) shadow_d[w] = RxTdata;
                    end
                    if (last_word) state_d = ST_TAIL;
                    else           idx_d   = idx_q + IDX_W'(1);
                end
                default: ;
            endcase

            if (RxTlast) begin
                if (RxTuser) begin
                    if (bad_q != '1) bad_d = bad_q + CNT_WIDTH'(1);
                end else if (state_q == ST_TAIL || (state_q == ST_PAYLOAD && last_word)) begin
                    // shadow_d already holds the final word when it arrives with RxTlast.
                    for (int unsigned i = 0; i < NUM_CMDS; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            payload_d[i] = shadow_d;
                            pulse_d[i]   = 1'b1;
                        end
                    end
                end else if ((state_q == ST_HDR && (|cand_upd)) || state_q == ST_PAYLOAD) begin
                    if (runt_q != '1) runt_d = runt_q + CNT_WIDTH'(1);
                end
                state_d = ST_HDR;
                idx_d   = '0;
                cand_d  = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HDR;
            idx_q     <= '0;
            cand_q    <= '1;
            sel_q     <= '0;
            pulse_q   <= '0;
            bad_q     <= '0;
            runt_q    <= '0;
            payload_q <= CmdDefaults;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cand_q    <= cand_d;
            sel_q     <= sel_d;
            pulse_q   <= pulse_d;
            bad_q     <= bad_d;
            runt_q    <= runt_d;
            payload_q <= payload_d;
        end
    end

    // Shadow is pure datapath: every word is rewritten before any commit.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign CmdPulse      = pulse_q;
    assign CmdPayload    = payload_q;
    assign BadFrameCount = bad_q;
    assign RuntCount     = runt_q;

endmodule
